// File: rtl/div_arbiter.sv
// Round-robin front end sharing one pipelined float divider among NUM_REQ clients,
// with a tag shadow pipeline and a credit-protected response FIFO. Optional macro: DIV_ARB_STATS_EN.
module div_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int DIV_LATENCY = 30,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_z,
  output logic [DATA_W-1:0]           div_a,
  output logic [DATA_W-1:0]           div_b,
  input  logic [DATA_W-1:0]           div_z
`ifdef DIV_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_issued,
  output logic [31:0]                 stat_stall
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic                    active_q;
  logic [ID_W-1:0]         rr_ptr_q;
  logic [CNT_W-1:0]        outstanding_q;
  logic [DATA_W-1:0]       div_a_q, div_b_q;
  logic [DIV_LATENCY:0]    tag_vld_q;
  logic [DIV_LATENCY:0][ID_W-1:0] tag_id_q;

  logic                    pop, credit_ok, can_issue, issue;
  logic [ID_W-1:0]         grant_id, idx;

  logic                    rsp_valid_q;
  logic [ID_W-1:0]         rsp_id_q;
  logic [DATA_W-1:0]       rsp_z_q;
  logic [ID_W+DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        mem_cnt_q;
  logic                    push, head_free, bypass, mem_wr, mem_rd;

  assign pop       = rsp_valid_q & rsp_ready;
  assign credit_ok = (outstanding_q - CNT_W'(pop)) < DEPTH_C;
  // active_q keeps req_ready low until the first edge after reset release
  assign can_issue = active_q & credit_ok;

  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    issue     = 1'b0;
    idx       = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(rr_ptr_q) + off) % NUM_REQ);
      if (!issue && can_issue && req_valid[idx]) begin
        issue    = 1'b1;
        grant_id = idx;
      end
    end
    if (issue) req_ready[grant_id] = 1'b1;
  end

  // Tag stage 0 travels with div_a/div_b; stage DIV_LATENCY lines up with div_z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q      <= 1'b0;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      outstanding_q <= '0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
    end else begin
      active_q      <= 1'b1;
      outstanding_q <= outstanding_q + CNT_W'(issue) - CNT_W'(pop);
      tag_vld_q     <= {tag_vld_q[DIV_LATENCY-1:0], issue};
      tag_id_q      <= {tag_id_q[DIV_LATENCY-1:0], grant_id};
      if (issue) begin
        rr_ptr_q <= grant_id;
        div_a_q  <= req_a[grant_id*DATA_W +: DATA_W];
        div_b_q  <= req_b[grant_id*DATA_W +: DATA_W];
      end
    end
  end

  assign div_a = div_a_q;
  assign div_b = div_b_q;

  // Head register is fed from memory, or directly by a push when memory is empty.
  assign push      = tag_vld_q[DIV_LATENCY];
  assign head_free = !rsp_valid_q || rsp_ready;
  assign bypass    = head_free && (mem_cnt_q == '0) && push;
  assign mem_wr    = push && !bypass;
  assign mem_rd    = head_free && (mem_cnt_q != '0);

  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[wr_ptr_q] <= {tag_id_q[DIV_LATENCY], div_z};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
    end else begin
      if (mem_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (mem_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      mem_cnt_q <= mem_cnt_q + CNT_W'(mem_wr) - CNT_W'(mem_rd);
      if (mem_rd) begin
        {rsp_id_q, rsp_z_q} <= mem_q[rd_ptr_q];
        rsp_valid_q         <= 1'b1;
      end else if (bypass) begin
        rsp_id_q    <= tag_id_q[DIV_LATENCY];
        rsp_z_q     <= div_z;
        rsp_valid_q <= 1'b1;
      end else if (head_free) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;

`ifdef DIV_ARB_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (issue) stat_issued_q <= stat_issued_q + 32'd1;
      if ((|req_valid) && !credit_ok && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Directed self-checking bench for div_arbiter with a behavioural divider stand-in and a response scoreboard.
module tb_div_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 30;
  localparam int FD  = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NR-1:0]      req_valid, req_ready;
  logic [NR*DW-1:0]   req_a, req_b;
  logic               rsp_valid, rsp_ready;
  logic [1:0]         rsp_id;
  logic [DW-1:0]      rsp_z, div_a, div_b, div_z;
`ifdef DIV_ARB_STATS_EN
  logic [31:0]        stat_issued, stat_stall;
`endif

  int total = 0;
  int bad   = 0;

  div_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .DIV_LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .div_a(div_a), .div_b(div_b), .div_z(div_z)
`ifdef DIV_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  // Divider stand-in: known quotients for the directed pairs, a reversible mix otherwise.
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
    return a ^ b;
  endfunction

  logic [31:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= fdiv(div_a, div_b);
    for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
  end
  assign div_z = dpipe[LAT-1];

  // Scoreboard: grants and pops are observed at the falling edge, ahead of the edge that commits them.
  logic [33:0] exp_q [$];
  int          n_issued = 0;
  int          n_popped = 0;
  logic [1:0]  mon_g;
  logic [33:0] mon_e;
  logic        mon_ok;
  int          mon_pop;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      n_issued = 0;
      n_popped = 0;
    end else begin
      mon_pop = (rsp_valid && rsp_ready) ? 1 : 0;
      if (mon_pop == 1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $error("FAIL unexpected_rsp: observed id=%0d z=%h required no response", rsp_id, rsp_z);
        end else begin
          mon_e = exp_q.pop_front();
          assert ({rsp_id, rsp_z} === mon_e) else begin
            bad++;
            $error("FAIL rsp_order: observed id=%0d z=%h required id=%0d z=%h", rsp_id, rsp_z, mon_e[33:32], mon_e[31:0]);
          end
        end
        n_popped++;
      end
      if (req_ready != '0) begin
        mon_ok = $onehot(req_ready) && ((req_ready & ~req_valid) == '0) && ((n_issued - n_popped - mon_pop) < FD);
        total++;
        assert (mon_ok === 1'b1) else begin
          bad++;
          $error("FAIL grant_legal: observed ready=%b valid=%b used=%0d required legal grant", req_ready, req_valid, n_issued - n_popped);
        end
        mon_g = '0;
        for (int l = 0; l < NR; l++) if (req_ready[l]) mon_g = 2'(l);
        exp_q.push_back({mon_g, fdiv(req_a[mon_g*DW +: DW], req_b[mon_g*DW +: DW])});
        n_issued++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h required=%h", tag, obs, expv);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] b);
    req_a[l*DW +: DW] = a;
    req_b[l*DW +: DW] = b;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !rsp_valid) break;
      to_pos();
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
    chk({tag, "_count"}, 64'(n_popped), 64'(n_issued));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int issues, stalls, cnt;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    to_pos(); to_pos();
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id",    64'(rsp_id),    64'd0);
    chk("rst_rsp_z",     64'(rsp_z),     64'd0);
    chk("rst_div_a",     64'(div_a),     64'd0);
    chk("rst_div_b",     64'(div_b),     64'd0);
    rst_n = 1'b1;
    to_pos(); to_pos();

    // Single op, latency and head stability
    set_lane(0, 32'h40C00000, 32'h40000000);
    req_valid = 4'b0001;
    @(negedge clk); chk("t1_grant", 64'(req_ready), 64'h1);
    to_pos(); req_valid = '0;
    chk("t1_div_a", 64'(div_a), 64'h40C00000);
    chk("t1_div_b", 64'(div_b), 64'h40000000);
    repeat (LAT) to_pos();
    chk("t1_not_early", 64'(rsp_valid), 64'd0);
    to_pos();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_id",    64'(rsp_id),    64'd0);
    chk("t1_rsp_z",     64'(rsp_z),     64'h40400000);
    to_pos();
    chk("t1_hold_valid", 64'(rsp_valid), 64'd1);
    chk("t1_hold_z",     64'(rsp_z),     64'h40400000);
    rsp_ready = 1'b1;
    to_pos();
    chk("t1_single", 64'(rsp_valid), 64'd0);

    // Round robin with all lanes, then with lanes 1 and 3 only
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      for (int l = 0; l < NR; l++) set_lane(l, 32'hA0000000 | (l << 24) | k, 32'h40000000 + l);
      @(negedge clk); chk("t2_grant", 64'(req_ready), 64'(4'b0001 << ((k + 1) % 4)));
      to_pos();
    end
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("t2_skip", 64'(req_ready), (k % 2 == 0) ? 64'h2 : 64'h8);
      to_pos();
    end
    req_valid = '0;
    drain("t2_drain");

    // Reset with ops in flight
    req_valid = 4'b1111;
    @(negedge clk); chk("t5_pre_grant", 64'(req_ready), 64'h1);
    repeat (10) to_pos();
    req_valid = '0;
    repeat (3) to_pos();
    rst_n = 1'b0; req_valid = 4'b1111;
    #2;
    chk("t5_req_ready", 64'(req_ready), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rsp_id",    64'(rsp_id),    64'd0);
    chk("t5_rsp_z",     64'(rsp_z),     64'd0);
    chk("t5_div_a",     64'(div_a),     64'd0);
    chk("t5_div_b",     64'(div_b),     64'd0);
    to_pos();
    rst_n = 1'b1; req_valid = '0;
    cnt = 0;
    repeat (LAT + 10) begin
      @(negedge clk); if (rsp_valid) cnt++;
      to_pos();
    end
    chk("t5_no_rsp", 64'(cnt), 64'd0);
    req_valid = 4'b1111;
    @(negedge clk); chk("t5_first_grant", 64'(req_ready), 64'h1);
    to_pos();
    rst_n = 1'b0; req_valid = '0;
    to_pos();
    rst_n = 1'b1;
    to_pos(); to_pos();

    // Lane-2 op, then back-pressure fills every credit
    rsp_ready = 1'b0;
    set_lane(2, 32'h3F800000, 32'h40800000);
    req_valid = 4'b0100;
    @(negedge clk); chk("t3_grant", 64'(req_ready), 64'h4);
    to_pos(); req_valid = '0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) break;
      to_pos();
    end
    chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t3_rsp_id",    64'(rsp_id),    64'd2);
    chk("t3_rsp_z",     64'(rsp_z),     64'h3E800000);
    rsp_ready = 1'b1;
    to_pos();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    issues = 0; stalls = 0;
    for (int k = 0; k < 100; k++) begin
      for (int l = 0; l < NR; l++) set_lane(l, 32'hB0000000 | (l << 24) | k, 32'h3F000000 + l);
      @(negedge clk);
      if (req_ready != '0) issues++; else stalls++;
      to_pos();
    end
    chk("t3_issues",    64'(issues),    64'(FD));
    chk("t3_ready_low", 64'(req_ready), 64'd0);
`ifdef DIV_ARB_STATS_EN
    chk("t6_stat_issued", 64'(stat_issued), 64'(FD + 1));
    chk("t6_stat_stall",  64'(stat_stall),  64'(100 - FD));
`endif

    // Full FIFO: pop and issue in the same cycle, credits stay exhausted
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_head_valid", 64'(rsp_valid), 64'd1);
    chk("t4_pop_issue",  64'(req_ready), 64'h8);
    to_pos();
    rsp_ready = 1'b0;
    @(negedge clk); chk("t4_full_again", 64'(req_ready), 64'd0);
    to_pos();
    req_valid = '0; rsp_ready = 1'b1;
    drain("t4_drain");
    chk("t4_issued", 64'(n_issued), 64'(FD + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
